// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: sequencer state encoding and elaboration helpers
package reset_seq_pkg;
  typedef enum logic [2:0] {ASSERT, WAIT_RELEASE, HOLD, RELEASE, RUN} state_t;
  function automatic int max(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/reset_debounce.sv
// reset_debounce: 2-FF synchroniser plus stability counter for one active-high request
module reset_debounce #(
  parameter int DEBOUNCE_CLKS = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic req_o
);
  localparam int CW = $clog2(DEBOUNCE_CLKS + 1);
  logic sync1_q, sync2_q, deb_q, deb_d, diff, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diff  = sync2_q != deb_q;
    hit   = cnt_q == CW'(DEBOUNCE_CLKS - 1);
    cnt_d = diff && !hit ? cnt_q + 1'b1 : '0;
    deb_d = diff && hit ? ~deb_q : deb_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end
  assign req_o = deb_q;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: merges debounced reset requests and releases domain resets in order
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                 NUM_SRC          = 2,
  parameter logic [NUM_SRC-1:0] SRC_ACTIVE_LOW   = '0,
  parameter int                 DEBOUNCE_CLKS    = 16,
  parameter int                 RESET_CLKS       = 7,
  parameter int                 NUM_DOMAINS      = 3,
  parameter int                 RELEASE_GAP_CLKS = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_SRC-1:0]     src_req_i,
  output logic [NUM_DOMAINS-1:0] domain_reset_o,
  output logic                   busy_o,
  output logic                   led_reset_o,
  output logic [NUM_SRC-1:0]     cause_o
);
  localparam int CW = $clog2(max(RESET_CLKS, RELEASE_GAP_CLKS) + 1);
  localparam int DW = $clog2(NUM_DOMAINS + 1);
  logic [NUM_SRC-1:0] req;
  logic req_any;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dom_q, dom_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic busy_q;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    reset_debounce #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_deb (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .raw_i  (src_req_i[i] ^ SRC_ACTIVE_LOW[i]),
      .req_o  (req[i])
    );
  end
  assign req_any = |req;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    rst_d   = rst_q;
    cause_d = cause_q;
    case (state_q)
      ASSERT: begin
        state_d = WAIT_RELEASE;
        rst_d   = '1;
        cnt_d   = '0;
        dom_d   = '0;
      end
      WAIT_RELEASE: if (!req_any) begin
        state_d = HOLD;
        cnt_d   = CW'(RESET_CLKS - 1);
      end
      HOLD: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        rst_d = rst_q & ~NUM_DOMAINS'(1);
        if (NUM_DOMAINS == 1) state_d = RUN;
        else begin
          state_d = RELEASE;
          cnt_d   = CW'(RELEASE_GAP_CLKS - 1);
          dom_d   = DW'(1);
        end
      end
      RELEASE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        rst_d = rst_q & ~(NUM_DOMAINS'(1) << dom_q);
        dom_d = dom_q + 1'b1;
        if (dom_q == DW'(NUM_DOMAINS - 1)) state_d = RUN;
        else cnt_d = CW'(RELEASE_GAP_CLKS - 1);
      end
      RUN: begin
        rst_d = req_any ? '1 : '0;
        if (req_any) begin
          state_d = ASSERT;
          cause_d = req;
        end
      end
      default: state_d = ASSERT;
    endcase
    // an aborted release is not a RUN exit, so cause is left alone
    if ((state_q == HOLD || state_q == RELEASE) && req_any) begin
      state_d = ASSERT;
      rst_d   = '1;
      cnt_d   = '0;
      dom_d   = '0;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      dom_q   <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      rst_q   <= rst_d;
      busy_q  <= |rst_d;
      cause_q <= cause_d;
    end
  end
  assign domain_reset_o = rst_q;
  assign busy_o         = busy_q;
  assign led_reset_o    = busy_q;
  assign cause_o        = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: random and directed stimulus on two configurations against a release-schedule model
module tb_reset_sequencer;
  localparam int PA = 0, PW = 1, PS = 2, PN = 3;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [1:0] src = 2'b10;
  logic [2:0] dom0;
  logic busy0, led0, dom1, busy1, led1;
  logic [1:0] cause0, cause1;
  int checks = 0, failures = 0;
  int pr[2] = '{7, 1};
  int pd[2] = '{16, 1};
  int pnd[2] = '{3, 1};
  int pg[2] = '{4, 4};
  logic [1:0] ms1[2], ms2[2], mdeb[2], mlast[2], mc[2];
  int mrun[2][2];
  int mph[2], mk[2];
  always #5 clk = ~clk;
  reset_sequencer #(.NUM_SRC(2), .SRC_ACTIVE_LOW(2'b10)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .src_req_i(src),
    .domain_reset_o(dom0), .busy_o(busy0), .led_reset_o(led0), .cause_o(cause0)
  );
  reset_sequencer #(.NUM_SRC(2), .SRC_ACTIVE_LOW(2'b10), .DEBOUNCE_CLKS(1), .RESET_CLKS(1),
                    .NUM_DOMAINS(1), .RELEASE_GAP_CLKS(4)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .src_req_i(src),
    .domain_reset_o(dom1), .busy_o(busy1), .led_reset_o(led1), .cause_o(cause1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      mph[j] = PA; mk[j] = 0; mc[j] = '0;
      ms1[j] = '0; ms2[j] = '0; mdeb[j] = '0; mlast[j] = '0;
      mrun[j][0] = 0; mrun[j][1] = 0;
    end
  endtask
  // domain i drops once R + i*G edges have passed since the hold began
  function automatic logic [2:0] exp_dom(input int j);
    logic [2:0] e = '0;
    for (int i = 0; i < pnd[j]; i++)
      e[i] = mph[j] == PS ? (mk[j] < pr[j] + i * pg[j]) : (mph[j] != PN);
    return e;
  endfunction
  task automatic step();
    if (reset_i) begin
      model_reset();
      return;
    end
    for (int j = 0; j < 2; j++) begin
      automatic logic req = |mdeb[j];
      case (mph[j])
        PA: mph[j] = PW;
        PW: if (!req) begin mph[j] = PS; mk[j] = 0; end
        PS: if (req) mph[j] = PA;
            else begin
              mk[j]++;
              if (mk[j] >= pr[j] + (pnd[j] - 1) * pg[j]) mph[j] = PN;
            end
        default: if (req) begin mph[j] = PA; mc[j] = mdeb[j]; end
      endcase
      for (int b = 0; b < 2; b++) begin
        automatic logic s = ms2[j][b];
        mrun[j][b] = (s == mlast[j][b]) ? mrun[j][b] + 1 : 1;
        mlast[j][b] = s;
        if (s != mdeb[j][b] && mrun[j][b] >= pd[j]) mdeb[j][b] = s;
      end
      ms2[j] = ms1[j];
      ms1[j] = src ^ 2'b10;
    end
  endtask
  task automatic compare();
    logic [2:0] e0, e1;
    e0 = exp_dom(0);
    e1 = exp_dom(1);
    chk("dom0", {29'b0, dom0}, {29'b0, e0});
    chk("busy0", {31'b0, busy0}, {31'b0, |e0});
    chk("led0", {31'b0, led0}, {31'b0, |e0});
    chk("cause0", {30'b0, cause0}, {30'b0, mc[0]});
    chk("dom1", {31'b0, dom1}, {31'b0, e1[0]});
    chk("busy1", {31'b0, busy1}, {31'b0, e1[0]});
    chk("led1", {31'b0, led1}, {31'b0, e1[0]});
    chk("cause1", {30'b0, cause1}, {30'b0, mc[1]});
  endtask
  task automatic cyc();
    @(posedge clk);
    step();
    @(negedge clk);
    compare();
  endtask
  task automatic run(input int n);
    repeat (n) cyc();
  endtask
  task automatic wait_dom(input logic [2:0] want, input int budget, input string tag);
    int n = 0;
    while (dom0 != want && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, {31'b0, n < budget}, 32'd1);
  endtask
  task automatic async_reset(input string tag);
    reset_i = 1'b1;
    model_reset();
    #1;
    chk({tag, "_dom"}, {29'b0, dom0}, 32'h7);
    chk({tag, "_busy"}, {31'b0, busy0}, 32'h1);
    chk({tag, "_cause"}, {30'b0, cause0}, 32'h0);
    compare();
  endtask
  initial begin
    int n;
    model_reset();
    @(negedge clk);
    compare();
    chk("por_dom", {29'b0, dom0}, 32'h7);
    run(3);
    reset_i = 1'b0;
    run(40);
    chk("por_run", {29'b0, dom0}, 32'h0);
    chk("por_cause", {30'b0, cause0}, 32'h0);
    src[0] = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!dom0[0] && n < 100);
    chk("btn_latency", n, 32'd19);
    run(40 - n);
    src[0] = 1'b0;
    run(80);
    chk("btn_cause", {30'b0, cause0}, 32'h1);
    repeat (6) begin
      src[1] = 1'b0;
      run(10);
      src[1] = 1'b1;
      run(5);
    end
    chk("bounce_norst", {29'b0, dom0}, 32'h0);
    src[1] = 1'b0;
    run(25);
    src[1] = 1'b1;
    run(80);
    chk("bounce_cause", {30'b0, cause0}, 32'h2);
    src[0] = 1'b1;
    run(25);
    src[0] = 1'b0;
    wait_dom(3'b110, 200, "abort_wait");
    cyc();
    src[0] = 1'b1;
    run(30);
    src[0] = 1'b0;
    run(80);
    chk("abort_run", {29'b0, dom0}, 32'h0);
    src[0] = 1'b1;
    run(25);
    src[0] = 1'b0;
    wait_dom(3'b100, 200, "rel_wait");
    async_reset("midrel");
    run(2);
    reset_i = 1'b0;
    run(60);
    chk("midrel_run", {29'b0, dom0}, 32'h0);
    repeat (2000) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(31) == 0) src[b] = ~src[b];
      if ($urandom_range(399) == 0) begin
        async_reset("rnd");
        cyc();
        reset_i = 1'b0;
      end
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
